// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes on both sides and registered result/zero.
// Single-cycle ops finish on the accept edge; MUL and DIVU/REMU iterate one bit per cycle.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SRL  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;

  state_t           state, nxt, tgt;
  logic             accept, last, rem_sel, div_ge;
  logic [SHW-1:0]   cnt, shamt;
  logic [WIDTH-1:0] x_q, y_q, acc_q;
  logic [WIDTH-1:0] alu_out, mul_acc, rem_new, quo_new, div_val;
  logic [WIDTH:0]   rem_sh;

  assign accept = in_valid && in_ready;
  assign last   = (cnt == SHW'(WIDTH - 1));
  assign shamt  = b[SHW-1:0];

  always_comb begin
    alu_out = a + b;
    case (op)
      OP_AND:  alu_out = a & b;
      OP_OR:   alu_out = a | b;
      OP_ADD:  alu_out = a + b;
      OP_SUB:  alu_out = a - b;
      OP_SLL:  alu_out = a << shamt;
      OP_SRL:  alu_out = a >> shamt;
      OP_SRA:  alu_out = $signed(a) >>> shamt;
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, a < b};
      OP_XOR:  alu_out = a ^ b;
      default: alu_out = a + b;
    endcase
  end

  always_comb begin
    tgt = DONE;
    if (op == OP_MUL) tgt = MUL;
    else if (op == OP_DIVU || op == OP_REMU) tgt = DIV;
  end

  // x_q holds multiplicand (MUL) or dividend/quotient shift register (DIV);
  // y_q holds multiplier or divisor; acc_q holds partial product or remainder.
  assign mul_acc = acc_q + (y_q[0] ? x_q : '0);
  assign rem_sh  = {acc_q, x_q[WIDTH-1]};
  assign div_ge  = rem_sh >= {1'b0, y_q};
  // A zero divisor always passes the compare, giving all-ones quotient and remainder = a.
  assign rem_new = WIDTH'(div_ge ? rem_sh - {1'b0, y_q} : rem_sh);
  assign quo_new = {x_q[WIDTH-2:0], div_ge};
  assign div_val = rem_sel ? rem_new : quo_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (accept) nxt = tgt;
      MUL:  if (last) nxt = DONE;
      DIV:  if (last) nxt = DONE;
      DONE: if (out_ready) nxt = accept ? tgt : IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == DONE);
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      cnt     <= '0;
      rem_sel <= 1'b0;
      result  <= '0;
      zero    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            rem_sel <= (op == OP_REMU);
            x_q     <= a;
            y_q     <= b;
            acc_q   <= '0;
            cnt     <= '0;
            if (tgt == DONE) begin
              result <= alu_out;
              zero   <= (alu_out == '0);
            end
          end
        end
        MUL: begin
          acc_q <= mul_acc;
          x_q   <= x_q << 1;
          y_q   <= y_q >> 1;
          cnt   <= cnt + 1'b1;
          if (last) begin
            result <= mul_acc;
            zero   <= (mul_acc == '0);
          end
        end
        DIV: begin
          acc_q <= rem_new;
          x_q   <= quo_new;
          cnt   <= cnt + 1'b1;
          if (last) begin
            result <= div_val;
            zero   <= (div_val == '0);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq at WIDTH = 32, plus hand-written
// backpressure/back-to-back and mid-operation reset sequences.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int unsigned errors = 0;
  int unsigned checks = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int unsigned lat;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op with out_ready high; returns result/zero, edges from accept
  // until out_valid is seen, and number of those cycles with in_ready low.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic z,
                        output int unsigned lat, output int unsigned busy);
    int unsigned n;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; op = 4'b0110;
    lat = 0; busy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!in_ready) busy++;
    end while (!out_valid && lat < 100);
    r = result;
    z = zero;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        z;
    int unsigned lat, busy, stale;

    vecs[0]  = '{4'b0010, 32'd7,         32'hFFFFFFFD, 32'd4,         1'b0, 1};  // ADD wrap
    vecs[1]  = '{4'b0110, 32'd5,         32'd5,        32'd0,         1'b1, 1};  // SUB -> zero
    vecs[2]  = '{4'b1001, 32'h80000000,  32'h24,       32'hF8000000,  1'b0, 1};  // SRA
    vecs[3]  = '{4'b0011, 32'h80000000,  32'h24,       32'h08000000,  1'b0, 1};  // SRL
    vecs[4]  = '{4'b0100, 32'hFFFFFFFF,  32'd1,        32'd1,         1'b0, 1};  // SLT
    vecs[5]  = '{4'b1010, 32'hFFFFFFFF,  32'd1,        32'd0,         1'b1, 1};  // SLTU
    vecs[6]  = '{4'b0000, 32'h0000F0F0,  32'h0000FF00, 32'h0000F000,  1'b0, 1};  // AND
    vecs[7]  = '{4'b0001, 32'h0000F0F0,  32'h0000FF00, 32'h0000FFF0,  1'b0, 1};  // OR
    vecs[8]  = '{4'b1000, 32'hA5A5A5A5,  32'hFFFFFFFF, 32'h5A5A5A5A,  1'b0, 1};  // XOR
    vecs[9]  = '{4'b0111, 32'd1,         32'h3F,       32'h80000000,  1'b0, 1};  // SLL low 5 bits
    vecs[10] = '{4'b1111, 32'd3,         32'd4,        32'd7,         1'b0, 1};  // unused -> ADD
    vecs[11] = '{4'b0100, 32'd1,         32'hFFFFFFFF, 32'd0,         1'b1, 1};  // SLT pos vs neg
    vecs[12] = '{4'b0101, 32'd12345,     32'd678,      32'h007FB6F6,  1'b0, 33}; // MUL
    vecs[13] = '{4'b0101, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFE,  1'b0, 33}; // MUL wrap
    vecs[14] = '{4'b0101, 32'd0,         32'd5,        32'd0,         1'b1, 33}; // MUL zero
    vecs[15] = '{4'b1011, 32'd100,       32'd7,        32'd14,        1'b0, 33}; // DIVU
    vecs[16] = '{4'b1100, 32'd100,       32'd7,        32'd2,         1'b0, 33}; // REMU
    vecs[17] = '{4'b1011, 32'd5,         32'd0,        32'hFFFFFFFF,  1'b0, 33}; // DIVU by 0
    vecs[18] = '{4'b1100, 32'd5,         32'd0,        32'd5,         1'b0, 33}; // REMU by 0
    vecs[19] = '{4'b1100, 32'd6,         32'd3,        32'd0,         1'b1, 33}; // REMU exact
    vecs[20] = '{4'b1011, 32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF,  1'b0, 33}; // DIVU by 1
    vecs[21] = '{4'b1100, 32'hFFFFFFFF,  32'h10,       32'h0000000F,  1'b0, 33}; // REMU large
    vecs[22] = '{4'b0101, 32'h00010000,  32'h00010000, 32'd0,         1'b1, 33}; // MUL overflow
    vecs[23] = '{4'b1011, 32'd7,         32'd100,      32'd0,         1'b1, 33}; // DIVU a<b

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    #2;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result",    result,             32'd0);
    chk("rst_zero",      {31'd0, zero},      32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, lat, busy);
      chk($sformatf("v%0d_result", i),  r,              vecs[i].res);
      chk($sformatf("v%0d_zero", i),    {31'd0, z},     {31'd0, vecs[i].z});
      chk($sformatf("v%0d_latency", i), lat,            vecs[i].lat);
      chk($sformatf("v%0d_busy", i),    busy,           vecs[i].lat - 1);
    end

    // Backpressure: OR result held 5 cycles while an ADD waits on in_valid.
    @(negedge clk);
    op = 4'b0001; a = 32'h00000F00; b = 32'h000000F0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    op = 4'b0010; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("hold%0d_result", k),    result,             32'h00000FF0);
      chk($sformatf("hold%0d_zero", k),      {31'd0, zero},      32'd0);
      chk($sformatf("hold%0d_in_ready", k),  {31'd0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_result",    result,             32'd2);
    chk("b2b_zero",      {31'd0, zero},      32'd0);

    // Reset during cycle 10 of a MUL.
    @(negedge clk);
    op = 4'b0101; a = 32'd12345; b = 32'd678; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("mid_busy_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result",    result,             32'd0);
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("mid_rst_zero",      {31'd0, zero},      32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_result", stale, 32'd0);
    run_op(4'b0010, 32'd2, 32'd3, r, z, lat, busy);
    chk("post_rst_result",  r,          32'd5);
    chk("post_rst_zero",    {31'd0, z}, 32'd0);
    chk("post_rst_latency", lat,        32'd1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
